// File: rtl/mult_rr_scheduler.sv
// Round-robin front end sharing one sequential signed multiplier (Start/Ready) among several clients.
// Optional feature: define MULT_RR_ZERO_BYPASS_EN to skip the multiplier when an operand is zero.
module mult_rr_scheduler #(
    parameter int Word_Length    = 6,
    parameter int Num_Requesters = 4,
    parameter int Timeout_Cycles = 64
) (
    input  logic                                  Clk_Input,
    input  logic                                  Reset_Input,
    input  logic [Num_Requesters-1:0]             Req_Input,
    input  logic [Num_Requesters*Word_Length-1:0] Multiplicand_Bus_Input,
    input  logic [Num_Requesters*Word_Length-1:0] Multiplier_Bus_Input,
    output logic [Num_Requesters-1:0]             Grant_Output,
    output logic [Num_Requesters-1:0]             Done_Output,
    output logic [2*Word_Length-1:0]              Product_Output,
    output logic                                  Error_Output,
    output logic                                  Busy_Output,
    output logic                                  Mult_Start_Output,
    output logic [Word_Length-1:0]                Mult_Multiplicand_Output,
    output logic [Word_Length-1:0]                Mult_Multiplier_Output,
    input  logic                                  Mult_Ready_Input,
    input  logic [2*Word_Length-1:0]              Mult_Product_Input
);

    localparam int W  = Word_Length;
    localparam int NR = Num_Requesters;
    localparam int PW = (NR > 2) ? $clog2(NR) : 1;
    localparam int TW = (Timeout_Cycles > 2) ? $clog2(Timeout_Cycles) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   owner_r;
    logic [PW-1:0]   winner_s;
    logic [PW-1:0]   next_ptr_s;
    logic [TW-1:0]   cnt_r;
    logic            ready_r;
    logic            ready_d_r;
    logic            bypass_r;
    logic            bypass_s;
    logic            complete_s;
    logic            timeout_s;
    logic [W-1:0]    cand_mcand_s;
    logic [W-1:0]    cand_mplier_s;
    logic [W-1:0]    mcand_r;
    logic [W-1:0]    mplier_r;
    logic [NR-1:0]   grant_r;
    logic [NR-1:0]   done_r;
    logic [2*W-1:0]  product_r;
    logic            error_r;
    logic            busy_r;
    logic            start_r;

    function automatic logic [PW-1:0] rr_pick(input logic [NR-1:0] req, input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NR; i++) begin
            idx = int'(ptr) + i;
            idx = (idx >= NR) ? (idx - NR) : idx;
            if (!found && req[idx[PW-1:0]]) begin
                pick  = idx[PW-1:0];
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NR-1:0] to_onehot(input logic [PW-1:0] idx);
        logic [NR-1:0] v;
        v      = {NR{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Arbitration winner, its operands, pointer advance and completion/timeout conditions
    always_comb begin
        winner_s      = rr_pick(Req_Input, ptr_r);
        cand_mcand_s  = Multiplicand_Bus_Input[int'(winner_s)*W +: W];
        cand_mplier_s = Multiplier_Bus_Input[int'(winner_s)*W +: W];
`ifdef MULT_RR_ZERO_BYPASS_EN
        bypass_s      = (cand_mcand_s == {W{1'b0}}) || (cand_mplier_s == {W{1'b0}});
`else
        bypass_s      = 1'b0;
`endif
        next_ptr_s    = (owner_r == PW'(NR - 1)) ? {PW{1'b0}} : (owner_r + 1'b1);
        // The delayed copy is forced high at launch, so only a fresh 0->1 edge counts
        complete_s    = ready_r & ~ready_d_r;
        timeout_s     = (cnt_r == TW'(Timeout_Cycles - 1));
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|Req_Input) next_state_s = ST_LAUNCH;
                else            next_state_s = ST_IDLE;
            end
            ST_LAUNCH: begin
                if (bypass_r) next_state_s = ST_DONE;
                else          next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (complete_s || timeout_s) next_state_s = ST_DONE;
                else                         next_state_s = ST_WAIT;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk_Input or negedge Reset_Input) begin
        if (!Reset_Input) state_r <= ST_IDLE;
        else              state_r <= next_state_s;
    end

    // Registered datapath, pulses and arbitration bookkeeping
    always_ff @(posedge Clk_Input or negedge Reset_Input) begin
        if (!Reset_Input) begin
            ptr_r     <= {PW{1'b0}};
            owner_r   <= {PW{1'b0}};
            cnt_r     <= {TW{1'b0}};
            ready_r   <= 1'b0;
            ready_d_r <= 1'b0;
            bypass_r  <= 1'b0;
            mcand_r   <= {W{1'b0}};
            mplier_r  <= {W{1'b0}};
            grant_r   <= {NR{1'b0}};
            done_r    <= {NR{1'b0}};
            product_r <= {(2*W){1'b0}};
            error_r   <= 1'b0;
            busy_r    <= 1'b0;
            start_r   <= 1'b0;
        end else begin
            grant_r <= {NR{1'b0}};
            done_r  <= {NR{1'b0}};
            error_r <= 1'b0;
            start_r <= 1'b0;
            busy_r  <= (next_state_s != ST_IDLE);
            ready_r <= Mult_Ready_Input;
            case (state_r)
                ST_IDLE: begin
                    if (|Req_Input) begin
                        owner_r  <= winner_s;
                        mcand_r  <= cand_mcand_s;
                        mplier_r <= cand_mplier_s;
                        bypass_r <= bypass_s;
                        grant_r  <= to_onehot(winner_s);
                        start_r  <= ~bypass_s;
                    end
                end
                ST_LAUNCH: begin
                    cnt_r     <= {TW{1'b0}};
                    ready_d_r <= 1'b1;
                    if (bypass_r) begin
                        product_r <= {(2*W){1'b0}};
                        done_r    <= to_onehot(owner_r);
                    end
                end
                ST_WAIT: begin
                    cnt_r     <= cnt_r + 1'b1;
                    ready_d_r <= ready_r;
                    if (complete_s) begin
                        product_r <= Mult_Product_Input;
                        done_r    <= to_onehot(owner_r);
                    end else if (timeout_s) begin
                        product_r <= {(2*W){1'b0}};
                        error_r   <= 1'b1;
                        done_r    <= to_onehot(owner_r);
                    end
                end
                ST_DONE: ptr_r <= next_ptr_s;
                default: ptr_r <= ptr_r;
            endcase
        end
    end

    assign Grant_Output             = grant_r;
    assign Done_Output              = done_r;
    assign Product_Output           = product_r;
    assign Error_Output             = error_r;
    assign Busy_Output              = busy_r;
    assign Mult_Start_Output        = start_r;
    assign Mult_Multiplicand_Output = mcand_r;
    assign Mult_Multiplier_Output   = mplier_r;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: job-level timestamp model, responder multiplier, directed + random traffic.
module tb_mult_rr_scheduler;
    localparam int W  = 6;
    localparam int N  = 4;
    localparam int TO = 64;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req   = '0;
    logic [N*W-1:0]   mcand_bus  = '0;
    logic [N*W-1:0]   mplier_bus = '0;
    logic [N-1:0]     grant, done;
    logic [2*W-1:0]   product;
    logic             error, busy, mstart;
    logic [W-1:0]     m_mcand, m_mplier;
    logic             mready = 1'b0;
    logic [2*W-1:0]   mprod  = '0;

    logic [W-1:0]     a_op [N];
    logic [W-1:0]     b_op [N];
    bit               mult_rand  = 1'b0;
    bit               mult_never = 1'b0;
    int               pass_cnt   = 0;
    int               total_cnt  = 0;

    mult_rr_scheduler #(.Word_Length(W), .Num_Requesters(N), .Timeout_Cycles(TO)) dut (
        .Clk_Input(clk), .Reset_Input(rst_n), .Req_Input(req),
        .Multiplicand_Bus_Input(mcand_bus), .Multiplier_Bus_Input(mplier_bus),
        .Grant_Output(grant), .Done_Output(done), .Product_Output(product),
        .Error_Output(error), .Busy_Output(busy), .Mult_Start_Output(mstart),
        .Mult_Multiplicand_Output(m_mcand), .Mult_Multiplier_Output(m_mplier),
        .Mult_Ready_Input(mready), .Mult_Product_Input(mprod)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Reference model: job timestamps (grant cycle g, done cycle), rotation pointer, ready history
    int               cyc = 0;
    int               m_phase = 0;
    int               m_ptr = 0;
    int               m_owner = 0;
    int               m_g = 0;
    bit               m_byp = 1'b0;
    bit               m_err = 1'b0;
    logic signed [W-1:0]   m_a = '0, m_b = '0;
    logic [2*W-1:0]   m_prod = '0;
    logic             rh0 = 1'b0, rh1 = 1'b0, rh2 = 1'b0;
    // Responder multiplier state
    int               mm_cnt = 0, mm_lat = 8;
    bit               mm_drop = 1'b0, mm_lag = 1'b0, mm_nev = 1'b0;
    logic signed [W-1:0]   mm_a = '0, mm_b = '0;

    always @(negedge clk) begin : model_cmp
        logic [N-1:0]          e_grant, e_done;
        logic                  e_err, e_busy, e_start;
        logic signed [2*W-1:0] sp;
        int                    j, idx;
        bit                    found;
        cyc++;
        rh2 = rh1; rh1 = rh0; rh0 = mready;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_err = 1'b0; m_byp = 1'b0;
            m_a = '0; m_b = '0; m_prod = '0;
        end else if (m_phase == 0) begin
            if (req != '0) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    idx = (m_ptr + i) % N;
                    if (!found && req[idx]) begin m_owner = idx; found = 1'b1; end
                end
                m_a = mcand_bus[m_owner*W +: W];
                m_b = mplier_bus[m_owner*W +: W];
`ifdef MULT_RR_ZERO_BYPASS_EN
                m_byp = (m_a == 0) || (m_b == 0);
`else
                m_byp = 1'b0;
`endif
                m_err = 1'b0; m_g = cyc; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            j = cyc - m_g - 1;
            if (m_byp) begin
                m_prod = '0; m_phase = 2;
            end else if (j >= 2 && rh1 && !rh2) begin
                sp = m_a * m_b; m_prod = sp; m_phase = 2;
            end else if (j == TO) begin
                m_prod = '0; m_err = 1'b1; m_phase = 2;
            end
        end else begin
            m_phase = 0; m_err = 1'b0; m_ptr = (m_owner + 1) % N;
        end

        e_grant = '0; e_done = '0;
        e_start = 1'b0;
        if (m_phase == 1 && cyc == m_g) begin e_grant[m_owner] = 1'b1; e_start = !m_byp; end
        if (m_phase == 2) e_done[m_owner] = 1'b1;
        e_err  = (m_phase == 2) && m_err;
        e_busy = (m_phase != 0);
        chk("cycle_handshake", {grant, done, error, busy, mstart}, {e_grant, e_done, e_err, e_busy, e_start});
        chk("cycle_data", {product, m_mcand, m_mplier}, {m_prod, m_a, m_b});

        if (!rst_n) begin
            mready = 1'b0; mm_cnt = 0; mm_drop = 1'b0;
        end else if (mstart) begin
            mm_a = m_mcand; mm_b = m_mplier;
            if (mult_rand) begin
                mm_lat = int'($urandom_range(1, 12));
                mm_lag = ($urandom_range(0, 1) == 1);
                mm_nev = ($urandom_range(0, 39) == 0);
            end else begin
                mm_lat = 8; mm_lag = 1'b0; mm_nev = mult_never;
            end
            mm_cnt = mm_nev ? 0 : mm_lat;
            if (mm_lag) mm_drop = 1'b1;
            else        mready = 1'b0;
        end else if (mm_drop) begin
            mready = 1'b0; mm_drop = 1'b0;
        end else if (mm_cnt > 0) begin
            mm_cnt--;
            if (mm_cnt == 0) begin mready = 1'b1; mprod = mm_a * mm_b; end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            mcand_bus[k*W +: W]  = a_op[k];
            mplier_bus[k*W +: W] = b_op[k];
        end
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int t = 0; t < 300; t++) begin
            if (idx < 0) begin
                tick();
                for (int k = 0; k < N; k++) if (grant[k]) idx = k;
            end
        end
        chk("grant_seen", (idx >= 0), 1'b1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!ok) begin
                tick();
                ok = (done != '0);
            end
        end
        chk("done_seen", ok, 1'b1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400; t++) if (busy) tick();
        chk("idle_seen", busy, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", {grant, done, error, busy, mstart, product, m_mcand, m_mplier}, 64'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int idx;
        int order [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < N; k++) begin a_op[k] = '0; b_op[k] = '0; end
        pack();
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_state", {grant, done, error, busy, mstart, product, m_mcand, m_mplier}, 64'd0);

        // Single client: -5 x 7
        a_op[1] = 6'h3B; b_op[1] = 6'd7; pack(); req = 4'b0010;
        wait_grant(idx);
        chk("t1_grant", grant, 4'b0010);
        chk("t1_start", mstart, 1'b1);
        req = 4'b0000;
        wait_done();
        chk("t1_done", done, 4'b0010);
        chk("t1_prod", product, 12'hFDD);
        wait_idle();

        // All clients held: rotation 0,1,2,3,0
        pulse_reset();
        for (int k = 0; k < N; k++) begin a_op[k] = W'($urandom_range(1, 63)); b_op[k] = W'($urandom_range(1, 63)); end
        pack(); req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(idx);
            order[n] = idx;
            if (n == 4) req = 4'b0000;
        end
        for (int n = 0; n < 5; n++) chk("t2_order", order[n], exp_order[n]);
        wait_done();
        wait_idle();

        // Pointer at 2 after serving client 1, then clients 3 and 0
        pulse_reset();
        a_op[1] = 6'd9; b_op[1] = 6'd2; pack(); req = 4'b0010;
        wait_grant(idx);
        req = 4'b0000;
        wait_done();
        a_op[3] = 6'h20; b_op[3] = 6'h20; a_op[0] = 6'h20; b_op[0] = 6'h1F; pack();
        req = 4'b1001;
        wait_grant(idx);
        chk("t3_first", idx, 3);
        req[3] = 1'b0;
        wait_done();
        chk("t3_prod_400", product, 12'h400);
        wait_grant(idx);
        chk("t3_second", idx, 0);
        req[0] = 1'b0;
        wait_done();
        chk("t3_prod_c20", product, 12'hC20);
        wait_idle();

        // Multiplier never ready: timeout
        mult_never = 1'b1;
        a_op[2] = 6'd3; b_op[2] = 6'd3; pack(); req = 4'b0100;
        wait_grant(idx);
        req = 4'b0000;
        wait_done();
        chk("t4_error", error, 1'b1);
        chk("t4_done", done, 4'b0100);
        chk("t4_prod", product, 12'h000);
        tick();
        chk("t4_busy_drop", busy, 1'b0);
        mult_never = 1'b0;

        // Reset during WAIT, then arbitration restarts from index 0
        a_op[2] = 6'd5; b_op[2] = 6'd6; pack(); req = 4'b0100;
        wait_grant(idx);
        req = 4'b0000;
        repeat (3) tick();
        pulse_reset();
        repeat (10) tick();
        a_op[1] = 6'd4; b_op[1] = 6'h3F; a_op[3] = 6'd2; b_op[3] = 6'd2; pack();
        req = 4'b1010;
        wait_grant(idx);
        chk("t5_from_zero", grant, 4'b0010);
        req = 4'b0000;
        wait_done();
        wait_idle();

`ifdef MULT_RR_ZERO_BYPASS_EN
        a_op[0] = 6'd0; b_op[0] = 6'h2F; pack(); req = 4'b0001;
        wait_grant(idx);
        chk("t6_no_start", mstart, 1'b0);
        req = 4'b0000;
        tick();
        chk("t6_done", done, 4'b0001);
        chk("t6_prod", product, 12'h000);
        wait_idle();
`endif

        // Random traffic with random multiplier latency, late Ready drop and occasional hang
        mult_rand = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (grant[k]) begin
                    a_op[k] = W'($urandom_range(0, 63));
                    b_op[k] = W'($urandom_range(0, 63));
                    req[k]  = ($urandom_range(0, 1) == 1);
                end else if (!req[k] && $urandom_range(0, 3) == 0) begin
                    a_op[k] = W'($urandom_range(0, 63));
                    b_op[k] = W'($urandom_range(0, 63));
                    req[k]  = 1'b1;
                end
            end
            pack();
        end
        req = 4'b0000;
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one sequential signed multiplier (Start/Ready handshake, 2*Word_Length product) among Num_Requesters clients.
- Round-robin arbitration; captures the winner's operands and pulses the multiplier Start.
- Waits for Ready, then returns the product to the winner with a one-cycle Done pulse.
- Sits between client blocks and the multiplier instance; it is the only driver of the multiplier's Start and operand inputs.

Parameters:
- Word_Length, 6, operand width; product is 2*Word_Length.
- Num_Requesters, 4, number of clients (2..8).
- Timeout_Cycles, 64, maximum cycles spent in WAIT before abort.

Ports:
- Clk_Input  in  1  single clock, rising edge.
- Reset_Input  in  1  asynchronous, active-low reset.
- Req_Input  in  Num_Requesters  per-client request level.
- Multiplicand_Bus_Input  in  Num_Requesters*Word_Length  client k operand at [k*W +: W], signed.
- Multiplier_Bus_Input  in  Num_Requesters*Word_Length  same packing, signed.
- Grant_Output  out  Num_Requesters  one-hot pulse: operands of that client captured.
- Done_Output  out  Num_Requesters  one-hot pulse: Product_Output valid for that client.
- Product_Output  out  2*Word_Length  last result, signed; held until next Done.
- Error_Output  out  1  one-cycle pulse on timeout.
- Busy_Output  out  1  high in any state except IDLE.
- Mult_Start_Output  out  1  to multiplier Start.
- Mult_Multiplicand_Output  out  Word_Length  registered operand to multiplier.
- Mult_Multiplier_Output  out  Word_Length  registered operand to multiplier.
- Mult_Ready_Input  in  1  multiplier Ready.
- Mult_Product_Input  in  2*Word_Length  multiplier product.

Behaviour:
- Reset (Reset_Input=0, asynchronous):
  - All outputs 0; state IDLE.
  - Round-robin pointer 0; owner register 0; timeout counter 0.
  - Reset mid-operation aborts the job with no Done and no Error.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - If Req_Input != 0, pick the first asserted index searching from pointer upward, with wrap.
  - Register owner and both operands; go to LAUNCH.
  - With no request, stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - Grant_Output[owner]=1 and Mult_Start_Output=1.
  - Clear timeout counter; go to WAIT.
- WAIT:
  - Sample Mult_Ready_Input each cycle, keeping a 1-cycle delayed copy.
  - Completion is a rising edge (previous 0, current 1); the delayed copy is forced to 1 on LAUNCH, so a Ready already high at launch is ignored.
  - On completion: capture Mult_Product_Input into Product_Output and go to DONE.
  - If the counter reaches Timeout_Cycles-1 with no completion: Product_Output=0, Error_Output pulse (same cycle as DONE entry), go to DONE.
- DONE (exactly 1 cycle):
  - Done_Output[owner]=1.
  - pointer = (owner+1) mod Num_Requesters; go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle t gives Grant at t+1.
  - Done arrives 2 cycles after the multiplier's Ready rising edge.
  - Minimum issue interval is 4 cycles plus multiplier time.
- Requester rules:
  - Hold Req and operands stable until Grant; operands may change after Grant.
  - Req still high after Done counts as a new request; it is serviced only after all other pending clients (fairness).
- Request changes outside IDLE are ignored until the next IDLE cycle.
- Mult operand outputs hold their value after completion.
- Exactly one Grant per Done; Grant and Done are never asserted together.

Optional Feature:
- Macro: MULT_RR_ZERO_BYPASS_EN.
- Defined: if either captured operand equals 0, IDLE goes directly to a 1-cycle LAUNCH with Grant but Mult_Start_Output=0, then straight to DONE with Product_Output=0. The multiplier is not started.
- Undefined: every job goes through the multiplier.

Test Plan:
- Setup: Word_Length=6, Num_Requesters=4, behavioural multiplier model whose Ready rises 8 cycles after Start.
- Req=4'b0010, slot1 = -5 x 7 -> Grant=0010 one cycle; Mult_Start one cycle; Done=0010 two cycles after Ready edge; Product_Output=12'hFDD (-35).
- Req=4'b1111 held after reset -> grant order 0,1,2,3,0; each client gets exactly one Done between its Grants.
- Pointer=2 (after serving 1), Req=4'b1001 -> grant 3 then 0; then -32 x -32 = 12'h400 and -32 x 31 = 12'hC20 (-992).
- Model never raises Ready -> after 64 WAIT cycles: Error pulse, Done to owner, Product_Output=0, Busy drops next cycle.
- Reset_Input low for 1 cycle during WAIT -> all outputs 0 immediately, no Done; next request granted from index 0.
- With MULT_RR_ZERO_BYPASS_EN: 0 x -17 -> Grant, Mult_Start stays 0, Done 1 cycle later, Product=0.
